// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller beside the ID stage of a 5-stage MIPS pipeline.
// Tracks in-flight writers in an EX/MEM/WB scoreboard and serialises control flow.
module pipeline_hazard_unit #(
  parameter int unsigned REG_ADDR_W     = 5,
  parameter bit          FORWARD_EN     = 1'b1,
  parameter bit          REGFILE_BYPASS = 1'b0,
  parameter int unsigned CTRL_TIMEOUT   = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  id_reg_write_i,
  input  logic [REG_ADDR_W-1:0] id_write_reg_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_ctrl_i,
  input  logic                  wb_redirect_i,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic                  ctrl_timeout_err_o
);

  localparam int unsigned WaitW = (CTRL_TIMEOUT > 1) ? $clog2(CTRL_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(CTRL_TIMEOUT - 1);

  typedef enum logic {StRun, StCtrlWait} state_e;

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  err_q;
  logic [CNT_W-1:0]      stall_count_q;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;

  // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]            sb_valid_q;
  logic [2:0]            sb_load_q;
  logic [REG_ADDR_W-1:0] sb_reg_q [3];

  logic [2:0] rs_hit, rt_hit, stall_ent;
  logic       data_stall;
  logic       timeout_hit;
  logic       issue;
  logic       accept;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rs_hit[i] = id_uses_rs_i & sb_valid_q[i] & (sb_reg_q[i] == id_rs_i);
      rt_hit[i] = id_uses_rt_i & sb_valid_q[i] & (sb_reg_q[i] == id_rt_i);
    end
    // Which scoreboard positions cannot be covered by forwarding or the regfile bypass.
    stall_ent[0] = FORWARD_EN ? sb_load_q[0] : 1'b1;
    stall_ent[1] = ~FORWARD_EN;
    stall_ent[2] = ~REGFILE_BYPASS;
    data_stall   = id_valid_i & (|((rs_hit | rt_hit) & stall_ent));
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_hit   = 1'b0;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (wb_redirect_i) begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else begin
          pc_hold_o     = data_stall;
          ifid_hold_o   = data_stall;
          idex_bubble_o = data_stall;
          if (id_valid_i && id_ctrl_i && !data_stall) begin
            state_d = StCtrlWait;
          end
        end
      end
      StCtrlWait: begin
        timeout_hit = ~wb_redirect_i & (wait_cnt_q == WaitLast);
        if (wb_redirect_i || timeout_hit) begin
          // PC loads the redirect target; the wrong-path fetch in IF/ID is dropped.
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          wait_cnt_d    = '0;
          state_d       = StRun;
        end else begin
          pc_hold_o     = 1'b1;
          ifid_hold_o   = 1'b1;
          idex_bubble_o = 1'b1;
          wait_cnt_d    = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    accept  = id_valid_i & ~idex_bubble_o;
    issue   = accept & id_reg_write_i & (id_write_reg_i != '0);
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (FORWARD_EN && accept) begin
      // Youngest producer wins; selects apply in this instruction's EX cycle.
      if (rs_hit[0])      fwd_a_d = 2'd1;
      else if (rs_hit[1]) fwd_a_d = 2'd2;
      if (rt_hit[0])      fwd_b_d = 2'd1;
      else if (rt_hit[1]) fwd_b_d = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      err_q         <= 1'b0;
      stall_count_q <= '0;
      fwd_a_q       <= 2'd0;
      fwd_b_q       <= 2'd0;
      sb_valid_q    <= '0;
      sb_load_q     <= '0;
      sb_reg_q[0]   <= '0;
      sb_reg_q[1]   <= '0;
      sb_reg_q[2]   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
      if (idex_bubble_o && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
      sb_valid_q  <= {sb_valid_q[1:0], issue};
      sb_load_q   <= {sb_load_q[1:0], issue & id_mem_read_i};
      sb_reg_q[2] <= sb_reg_q[1];
      sb_reg_q[1] <= sb_reg_q[0];
      sb_reg_q[0] <= issue ? id_write_reg_i : '0;
    end
  end

  assign fwd_a_sel_o        = fwd_a_q;
  assign fwd_b_sel_o        = fwd_b_q;
  assign stall_count_o      = stall_count_q;
  assign ctrl_timeout_err_o = err_q | timeout_hit;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomised bench: three hazard-unit configurations run side by side, each against
// a distance-based reference model of in-flight writers and control-flow waits.
module tb_pipeline_hazard_unit;

  localparam int NC      = 3;
  localparam int RW      = 5;
  localparam int TIMEOUT = 8;
  localparam int NCYC    = 2000;
  localparam bit CFG_FWD  [NC] = '{1'b1, 1'b0, 1'b0};
  localparam bit CFG_BYP  [NC] = '{1'b0, 1'b0, 1'b1};
  localparam int CFG_CNTW [NC] = '{16, 16, 4};

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          urs;
    logic          urt;
    logic          rw;
    logic [RW-1:0] wr;
    logic          ld;
    logic          ctrl;
  } instr_t;

  typedef struct packed {
    int            cyc;
    logic [RW-1:0] rg;
    logic          ld;
  } wr_t;

  logic   clk = 1'b0;
  logic   reset;
  instr_t id    [NC];
  logic   redir [NC];

  wire        pc_hold    [NC];
  wire        ifid_hold  [NC];
  wire        ifid_flush [NC];
  wire        idex_bub   [NC];
  wire        err        [NC];
  wire [1:0]  fa         [NC];
  wire [1:0]  fb         [NC];
  wire [15:0] scnt       [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int W = CFG_CNTW[g];
    wire [W-1:0] cnt;
    pipeline_hazard_unit #(
      .REG_ADDR_W    (RW),
      .FORWARD_EN    (CFG_FWD[g]),
      .REGFILE_BYPASS(CFG_BYP[g]),
      .CTRL_TIMEOUT  (TIMEOUT),
      .CNT_W         (W)
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .id_valid_i        (id[g].valid),
      .id_rs_i           (id[g].rs),
      .id_rt_i           (id[g].rt),
      .id_uses_rs_i      (id[g].urs),
      .id_uses_rt_i      (id[g].urt),
      .id_reg_write_i    (id[g].rw),
      .id_write_reg_i    (id[g].wr),
      .id_mem_read_i     (id[g].ld),
      .id_ctrl_i         (id[g].ctrl),
      .wb_redirect_i     (redir[g]),
      .pc_hold_o         (pc_hold[g]),
      .ifid_hold_o       (ifid_hold[g]),
      .ifid_flush_o      (ifid_flush[g]),
      .idex_bubble_o     (idex_bub[g]),
      .fwd_a_sel_o       (fa[g]),
      .fwd_b_sel_o       (fb[g]),
      .stall_count_o     (cnt),
      .ctrl_timeout_err_o(err[g])
    );
    assign scnt[g] = 16'(cnt);
  end

  // Reference model state
  wr_t wq [NC][$];
  bit  m_wait [NC];
  int  m_wcnt [NC];
  bit  m_err  [NC];
  int  m_scnt [NC];
  int  m_fa   [NC];
  int  m_fb   [NC];
  bit  hold_prev [NC];
  int  now;

  int n_vec;
  int n_bad;

  task automatic check(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d cycle %0d: got %0d, expected %0d", tag, k, now, got, exp);
    end
  endtask

  // A writer issued at cycle c sits at distance now-c: 1 = EX, 2 = MEM, 3 = WB.
  function automatic bit src_stall(int k, logic [RW-1:0] src);
    bit s = 1'b0;
    for (int i = 0; i < wq[k].size(); i++) begin
      int d = now - wq[k][i].cyc;
      if (wq[k][i].rg == src) begin
        if (d == 1 && (!CFG_FWD[k] || wq[k][i].ld)) s = 1'b1;
        if (d == 2 && !CFG_FWD[k]) s = 1'b1;
        if (d == 3 && !CFG_BYP[k]) s = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic int src_fwd(int k, logic [RW-1:0] src);
    int best = 99;
    for (int i = 0; i < wq[k].size(); i++) begin
      int d = now - wq[k][i].cyc;
      if (wq[k][i].rg == src && d >= 1 && d <= 2 && d < best) best = d;
    end
    return (!CFG_FWD[k] || best == 99) ? 0 : best;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.valid = ($urandom_range(0, 9) != 0);
    x.rs    = 5'($urandom_range(0, 4));
    x.rt    = 5'($urandom_range(0, 4));
    x.urs   = ($urandom_range(0, 3) != 0);
    x.urt   = ($urandom_range(0, 2) != 0);
    x.rw    = ($urandom_range(0, 2) != 0);
    x.wr    = 5'($urandom_range(0, 4));
    x.ld    = ($urandom_range(0, 3) == 0);
    x.ctrl  = ($urandom_range(0, 11) == 0);
    return x;
  endfunction

  initial begin
    bit do_rst;
    n_vec = 0;
    n_bad = 0;
    now   = 0;
    reset = 1'b1;
    for (int k = 0; k < NC; k++) begin
      id[k]        = '0;
      redir[k]     = 1'b0;
      hold_prev[k] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int c = 0; c < NCYC; c++) begin
      for (int k = 0; k < NC; k++) begin
        if (!hold_prev[k]) id[k] = rand_instr();
        redir[k] = m_wait[k] ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 24) == 0);
      end
      do_rst = (c == 0) || ($urandom_range(0, 299) == 0) ||
               (m_wait[0] && m_wcnt[0] == 2 && $urandom_range(0, 3) == 0);
      if (do_rst) begin
        reset = 1'b1;
        for (int k = 0; k < NC; k++) begin
          id[k]        = '0;
          redir[k]     = 1'b0;
          hold_prev[k] = 1'b0;
          wq[k].delete();
          m_wait[k] = 1'b0;
          m_wcnt[k] = 0;
          m_err[k]  = 1'b0;
          m_scnt[k] = 0;
          m_fa[k]   = 0;
          m_fb[k]   = 0;
        end
      end

      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        bit stall, to, e_pc, e_ifh, e_fl, e_bub, accept, leave;
        stall = id[k].valid && ((id[k].urs && src_stall(k, id[k].rs)) ||
                                (id[k].urt && src_stall(k, id[k].rt)));
        to    = 1'b0;
        leave = 1'b0;
        if (m_wait[k]) begin
          to    = !redir[k] && (m_wcnt[k] + 1 == TIMEOUT);
          leave = redir[k] || to;
          e_pc  = !leave;
          e_ifh = !leave;
          e_fl  = leave;
          e_bub = 1'b1;
        end else if (redir[k]) begin
          e_pc  = 1'b0;
          e_ifh = 1'b0;
          e_fl  = 1'b1;
          e_bub = 1'b1;
        end else begin
          e_pc  = stall;
          e_ifh = stall;
          e_fl  = 1'b0;
          e_bub = stall;
        end

        check("pc_hold",     k, 32'(pc_hold[k]),    32'(e_pc));
        check("ifid_hold",   k, 32'(ifid_hold[k]),  32'(e_ifh));
        check("ifid_flush",  k, 32'(ifid_flush[k]), 32'(e_fl));
        check("idex_bubble", k, 32'(idex_bub[k]),   32'(e_bub));
        check("fwd_a_sel",   k, 32'(fa[k]),         32'(m_fa[k]));
        check("fwd_b_sel",   k, 32'(fb[k]),         32'(m_fb[k]));
        check("stall_count", k, 32'(scnt[k]),       32'(m_scnt[k]));
        check("timeout_err", k, 32'(err[k]),        32'(m_err[k] || to));

        accept  = id[k].valid && !e_bub;
        m_fa[k] = (accept && id[k].urs) ? src_fwd(k, id[k].rs) : 0;
        m_fb[k] = (accept && id[k].urt) ? src_fwd(k, id[k].rt) : 0;
        if (accept && id[k].rw && id[k].wr != 0) begin
          wq[k].push_back('{cyc: now, rg: id[k].wr, ld: id[k].ld});
        end
        if (e_bub && m_scnt[k] < (1 << CFG_CNTW[k]) - 1) m_scnt[k]++;
        if (to) m_err[k] = 1'b1;
        if (m_wait[k]) begin
          if (leave) begin
            m_wait[k] = 1'b0;
            m_wcnt[k] = 0;
          end else begin
            m_wcnt[k]++;
          end
        end else if (!redir[k] && id[k].valid && id[k].ctrl && !stall) begin
          m_wait[k] = 1'b1;
          m_wcnt[k] = 0;
        end
        hold_prev[k] = e_ifh;
      end
      reset = 1'b0;

      now++;
      for (int k = 0; k < NC; k++) begin
        while (wq[k].size() > 0 && now - wq[k][0].cyc > 3) void'(wq[k].pop_front());
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
